// File: rtl/detector_jogada.sv
// Debounced move detector: synchronizes the player switches, filters presses and releases,
// and registers a one-hot move with a single-cycle accept or reject pulse.
module detector_jogada #(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] chaves,
  output logic [3:0] jogada,
  output logic       jogada_feita,
  output logic       jogada_invalida,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    ESPERA       = 3'd0,
    FILTRA       = 3'd1,
    REGISTRA     = 3'd2,
    SOLTA        = 3'd3,
    FILTRA_SOLTA = 3'd4
  } estado_t;

  localparam logic [3:0] DB_LIMITE = 4'(DEBOUNCE_CYCLES);

  estado_t    estado;
  logic [3:0] chaves_m;
  logic [3:0] chaves_s;
  logic [3:0] amostra;
  logic [3:0] contador;
  logic       amostra_one_hot;

  assign amostra_one_hot = (amostra != 4'b0000) && ((amostra & (amostra - 4'd1)) == 4'b0000);
  assign db_estado       = estado;

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chaves_m <= 4'b0000;
      chaves_s <= 4'b0000;
    end else begin
      chaves_m <= chaves;
      chaves_s <= chaves_m;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado          <= ESPERA;
      contador        <= 4'd0;
      amostra         <= 4'b0000;
      jogada          <= 4'b0000;
      jogada_feita    <= 1'b0;
      jogada_invalida <= 1'b0;
    end else begin
      jogada_feita    <= 1'b0;
      jogada_invalida <= 1'b0;
      case (estado)
        ESPERA: begin
          if (habilita && (chaves_s != 4'b0000)) begin
            estado   <= FILTRA;
            contador <= 4'd1;
            amostra  <= chaves_s;
          end
        end
        FILTRA: begin
          if (chaves_s == 4'b0000) begin
            estado <= ESPERA;
          end else if (chaves_s != amostra) begin
            amostra  <= chaves_s;
            contador <= 4'd1;
          end else if (contador >= DB_LIMITE) begin
            // Pulses are registered here so they are high exactly during REGISTRA.
            estado <= REGISTRA;
            if (amostra_one_hot) begin
              jogada       <= amostra;
              jogada_feita <= 1'b1;
            end else begin
              jogada_invalida <= 1'b1;
            end
          end else if (contador != 4'hF) begin
            contador <= contador + 4'd1;
          end
        end
        REGISTRA: begin
          estado <= SOLTA;
        end
        SOLTA: begin
          if (chaves_s == 4'b0000) begin
            estado   <= FILTRA_SOLTA;
            contador <= 4'd1;
          end
        end
        FILTRA_SOLTA: begin
          if (chaves_s != 4'b0000) begin
            estado <= SOLTA;
          end else if (contador >= DB_LIMITE) begin
            estado <= ESPERA;
          end else if (contador != 4'hF) begin
            contador <= contador + 4'd1;
          end
        end
        default: begin
          estado <= ESPERA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada at the default debounce length of 2.
module tb_detector_jogada;

  logic       clock;
  logic       reset;
  logic       habilita;
  logic [3:0] chaves;
  logic [3:0] jogada;
  logic       jogada_feita;
  logic       jogada_invalida;
  logic [2:0] db_estado;

  int total = 0;
  int bad   = 0;
  int n_feita;
  int n_inval;

  detector_jogada #(.DEBOUNCE_CYCLES(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .habilita       (habilita),
    .chaves         (chaves),
    .jogada         (jogada),
    .jogada_feita   (jogada_feita),
    .jogada_invalida(jogada_invalida),
    .db_estado      (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, sample 1 time unit later, tally pulses, check exclusivity.
  task automatic step();
    @(posedge clock);
    #1;
    if (jogada_feita === 1'b1) n_feita++;
    if (jogada_invalida === 1'b1) n_inval++;
    chk("pulse_exclusive", int'(jogada_feita & jogada_invalida), 0);
  endtask

  logic [2:0] exp_st [5];
  logic       exp_fd [5];

  initial begin
    reset    = 1'b0;
    habilita = 1'b0;
    chaves   = 4'b0000;
    n_feita  = 0;
    n_inval  = 0;
    exp_st   = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3};
    exp_fd   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state
    step();
    chk("rst_estado", int'(db_estado), 0);
    chk("rst_jogada", int'(jogada), 0);
    chk("rst_feita", int'(jogada_feita), 0);
    chk("rst_inval", int'(jogada_invalida), 0);
    reset = 1'b1;
    step();

    // One-hot press 0010: state trace 0,1,1,2,3 after edges k+1..k+5
    habilita = 1'b1;
    chaves   = 4'b0010;
    step();
    chk("p1_edge_k_estado", int'(db_estado), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("p1_estado_%0d", i), int'(db_estado), int'(exp_st[i]));
      chk($sformatf("p1_feita_%0d", i), int'(jogada_feita), int'(exp_fd[i]));
      if (i == 3) chk("p1_jogada_at_pulse", int'(jogada), 4'b0010);
    end
    chk("p1_jogada_hold", int'(jogada), 4'b0010);
    chaves = 4'b0000;
    for (int i = 0; i < 6; i++) step();
    chk("p1_back_espera", int'(db_estado), 0);

    // Long hold 0100: one pulse only, then release filter 3 -> 4 -> 0
    n_feita = 0;
    n_inval = 0;
    chaves  = 4'b0100;
    for (int i = 0; i < 20; i++) step();
    chk("p2_feita_count", n_feita, 1);
    chk("p2_inval_count", n_inval, 0);
    chk("p2_estado_held", int'(db_estado), 3);
    chk("p2_jogada", int'(jogada), 4'b0100);
    chaves = 4'b0000;
    step();
    step();
    chk("p2_rel_solta", int'(db_estado), 3);
    step();
    chk("p2_rel_filtra1", int'(db_estado), 4);
    step();
    chk("p2_rel_filtra2", int'(db_estado), 4);
    step();
    chk("p2_rel_espera", int'(db_estado), 0);

    // Single-cycle glitch on 0001
    n_feita = 0;
    n_inval = 0;
    chaves  = 4'b0001;
    step();
    chaves = 4'b0000;
    for (int i = 0; i < 8; i++) step();
    chk("p3_no_feita", n_feita, 0);
    chk("p3_no_inval", n_inval, 0);
    chk("p3_jogada_kept", int'(jogada), 4'b0100);
    chk("p3_estado", int'(db_estado), 0);

    // Two keys 0011 for 5 cycles: invalid pulse, move kept
    n_feita = 0;
    n_inval = 0;
    chaves  = 4'b0011;
    for (int i = 0; i < 4; i++) step();
    chk("p4_no_early_inval", n_inval, 0);
    step();
    chk("p4_inval_pulse", int'(jogada_invalida), 1);
    chk("p4_estado_reg", int'(db_estado), 2);
    chaves = 4'b0000;
    for (int i = 0; i < 8; i++) step();
    chk("p4_inval_count", n_inval, 1);
    chk("p4_feita_count", n_feita, 0);
    chk("p4_jogada_kept", int'(jogada), 4'b0100);
    chk("p4_estado", int'(db_estado), 0);

    // habilita low blocks acceptance; raising it with key held accepts 1000
    n_feita  = 0;
    n_inval  = 0;
    habilita = 1'b0;
    chaves   = 4'b1000;
    for (int i = 0; i < 5; i++) step();
    chk("p5_blocked_feita", n_feita, 0);
    chk("p5_blocked_estado", int'(db_estado), 0);
    habilita = 1'b1;
    step();
    chk("p5_filtra", int'(db_estado), 1);
    step();
    chk("p5_not_yet", int'(jogada_feita), 0);
    step();
    chk("p5_feita", int'(jogada_feita), 1);
    chk("p5_jogada", int'(jogada), 4'b1000);
    // habilita dropping mid-sequence must not abort the release handshake
    habilita = 1'b0;
    chaves   = 4'b0000;
    for (int i = 0; i < 6; i++) step();
    chk("p5_estado_end", int'(db_estado), 0);
    chk("p5_feita_count", n_feita, 1);
    habilita = 1'b1;

    // Asynchronous reset while in FILTRA
    chaves = 4'b0001;
    step();
    step();
    step();
    chk("p6_in_filtra", int'(db_estado), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("p6_async_estado", int'(db_estado), 0);
    chk("p6_async_jogada", int'(jogada), 0);
    chk("p6_async_feita", int'(jogada_feita), 0);
    chk("p6_async_inval", int'(jogada_invalida), 0);
    step();
    step();
    chk("p6_hold_estado", int'(db_estado), 0);
    n_feita = 0;
    n_inval = 0;
    reset   = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("p6_no_early_pulse", n_feita + n_inval, 0);
    step();
    chk("p6_feita", int'(jogada_feita), 1);
    chk("p6_jogada", int'(jogada), 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
